// File: rtl/bit_normalizer_pkg.sv
// bit_normalizer_pkg
// Shared widths, function codes, FSM state encoding and SCAN step
// decision type for the bit normalizer.
package bit_normalizer_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SKIP_WIDTH  = 8;
    localparam int FUNCT_WIDTH = 2;
    localparam int SHAMT_WIDTH = 6;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT2_CLZ = 2'd0;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT2_CLO = 2'd1;

    // Count at which the whole word has been consumed.
    localparam logic [SHAMT_WIDTH-1:0] CNT_FULL     = 6'(DATA_WIDTH);
    // Largest count from which a coarse step cannot overshoot CNT_FULL.
    localparam logic [SHAMT_WIDTH-1:0] COARSE_LIMIT = 6'(DATA_WIDTH - SKIP_WIDTH);
    localparam logic [SHAMT_WIDTH-1:0] COARSE_INC   = 6'(SKIP_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_STOP   = 2'd0,
        STEP_COARSE = 2'd1,
        STEP_FINE   = 2'd2
    } step_t;

endpackage

// File: rtl/bit_normalizer_if.sv
// bit_normalizer_if
// Request/result bundle between the EX pipeline and the bit normalizer.
//   flush, start, funct, operand_1 : request side (pipeline -> unit)
//   busy, done, result_norm, result_shamt : status/result (unit -> pipeline)
// master: pipeline side, slave: the normalizer.
interface bit_normalizer_if;
    import bit_normalizer_pkg::*;

    logic                   flush;
    logic                   start;
    logic [FUNCT_WIDTH-1:0] funct;
    logic [DATA_WIDTH-1:0]  operand_1;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  result_norm;
    logic [SHAMT_WIDTH-1:0] result_shamt;

    modport master (
        output flush, start, funct, operand_1,
        input  busy, done, result_norm, result_shamt
    );

    modport slave (
        input  flush, start, funct, operand_1,
        output busy, done, result_norm, result_shamt
    );

endinterface

// File: rtl/bit_normalizer.sv
// bit_normalizer
// Multi-cycle EX unit: strips leading zeros (CLZ) or leading ones (CLO)
// from operand_1 by shifting left with zero fill, returning the shifted
// word and the shift amount (the CLZ/CLO count).
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : bit_normalizer_if.slave (flush/start/funct/operand_1 in,
//          busy/done/result_norm/result_shamt out)
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | one stop/coarse/fine decision per cycle, busy high
// DONE  | results valid, done pulses for one cycle
module bit_normalizer
    import bit_normalizer_pkg::*;
(
    input logic            clk,
    input logic            rst,
    bit_normalizer_if.slave bus
);

    state_t                 state;
    state_t                 state_nxt;
    step_t                  step;
    logic [DATA_WIDTH-1:0]  work;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   pol;
    logic                   pass;
    logic [DATA_WIDTH-1:0]  result_norm;
    logic [SHAMT_WIDTH-1:0] result_shamt;
    logic                   accept;

    assign accept = (state == IDLE) && bus.start && !bus.flush;

    // Stop has priority; the coarse step also requires cnt<=24 so the
    // count can never pass 32. In CLO mode the zero fill ends the scan
    // because a shifted-in 0 differs from pol.
    always_comb begin
        step = STEP_FINE;
        if (pass || (cnt == CNT_FULL) || (work[DATA_WIDTH-1] != pol)) begin
            step = STEP_STOP;
        end else if ((work[DATA_WIDTH-1 -: SKIP_WIDTH] == {SKIP_WIDTH{pol}}) &&
                     (cnt <= COARSE_LIMIT)) begin
            step = STEP_COARSE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (step == STEP_STOP) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work         <= '0;
            cnt          <= '0;
            pol          <= 1'b0;
            pass         <= 1'b0;
            result_norm  <= '0;
            result_shamt <= '0;
        end else if (accept) begin
            work <= bus.operand_1;
            cnt  <= '0;
            pol  <= (bus.funct == FUNCT2_CLO);
            pass <= (bus.funct != FUNCT2_CLZ) && (bus.funct != FUNCT2_CLO);
        end else if ((state == SCAN) && !bus.flush) begin
            case (step)
                STEP_STOP: begin
                    result_norm  <= work;
                    result_shamt <= cnt;
                end
                STEP_COARSE: begin
                    work <= work << SKIP_WIDTH;
                    cnt  <= cnt + COARSE_INC;
                end
                default: begin
                    work <= work << 1;
                    cnt  <= cnt + 6'd1;
                end
            endcase
        end
    end

    assign bus.busy         = (state == SCAN);
    assign bus.done         = (state == DONE);
    assign bus.result_norm  = result_norm;
    assign bus.result_shamt = result_shamt;

endmodule

// File: tb/tb_bit_normalizer.sv
// tb_bit_normalizer
// Directed bench for bit_normalizer: latency, busy window, results,
// pass-through, flush, back-to-back start and asynchronous reset.
module tb_bit_normalizer;
    import bit_normalizer_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    bit_normalizer_if bus ();

    bit_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Start in cycle 0 (driven at the negedge, accepted at the next posedge),
    // then watch negedges of cycles 1.. for done. Returns at the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] op,
                          input logic [31:0] exp_norm, input logic [5:0] exp_shamt,
                          input int exp_lat);
        int lat;
        int busy_cnt;
        lat      = 99;
        busy_cnt = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct     = f;
        bus.operand_1 = op;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_1 = 32'hDEAD_BEEF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, "_norm"}, bus.result_norm, exp_norm);
        chk({tag, "_shamt"}, 32'(bus.result_shamt), 32'(exp_shamt));
    endtask

    initial begin
        int done_cnt;
        int d1;
        int d2;
        logic [31:0] n1;
        logic [5:0]  s1;
        vectors       = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.start     = 1'b0;
        bus.funct     = FUNCT2_CLZ;
        bus.operand_1 = '0;

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_norm", bus.result_norm, 32'd0);
        chk("reset_shamt", 32'(bus.result_shamt), 32'd0);
        rst = 1'b1;

        run_op("clz_msb",    FUNCT2_CLZ, 32'h8000_0000, 32'h8000_0000, 6'd0,  2);
        run_op("clz_one",    FUNCT2_CLZ, 32'h0000_0001, 32'h8000_0000, 6'd31, 12);
        run_op("clz_zero",   FUNCT2_CLZ, 32'h0000_0000, 32'h0000_0000, 6'd32, 6);
        run_op("clo_ones",   FUNCT2_CLO, 32'hFFFF_FFFF, 32'h0000_0000, 6'd32, 6);
        run_op("clo_fff0",   FUNCT2_CLO, 32'hFFFF_FFF0, 32'h0000_0000, 6'd28, 9);
        run_op("clo_7fff",   FUNCT2_CLO, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'd0,  2);
        run_op("clz_byte",   FUNCT2_CLZ, 32'h00F0_0000, 32'hF000_0000, 6'd8,  3);
        run_op("clo_byte",   FUNCT2_CLO, 32'hFF7F_FFFF, 32'h7FFF_FF00, 6'd8,  3);
        run_op("clz_0100",   FUNCT2_CLZ, 32'h0000_0100, 32'h8000_0000, 6'd23, 11);
        run_op("pass",       2'd2,       32'h1234_5678, 32'h1234_5678, 6'd0,  2);

        // Flush in cycle 4 of a long CLZ: no done, results keep 0x12345678/0.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct     = FUNCT2_CLZ;
        bus.operand_1 = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        done_cnt  = 0;
        @(negedge clk);
        chk("flush_idle_busy", 32'(bus.busy), 32'd0);
        for (int c = 0; c < 14; c++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        chk("flush_no_done", 32'(done_cnt), 32'd0);
        chk("flush_norm_kept", bus.result_norm, 32'h1234_5678);
        chk("flush_shamt_kept", 32'(bus.result_shamt), 32'd0);

        // start together with flush is not accepted.
        bus.start     = 1'b1;
        bus.flush     = 1'b1;
        bus.operand_1 = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        done_cnt  = 0;
        @(negedge clk);
        chk("startflush_busy", 32'(bus.busy), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (bus.done || bus.busy) done_cnt++;
            @(negedge clk);
        end
        chk("startflush_idle", 32'(done_cnt), 32'd0);

        // start held high, operand alternating A/B every cycle.
        bus.funct     = FUNCT2_CLZ;
        bus.operand_1 = 32'h8000_0000;
        bus.start     = 1'b1;
        d1 = 0;
        d2 = 0;
        n1 = '0;
        s1 = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            bus.operand_1 = (c % 2 == 1) ? 32'h00F0_0000 : 32'h8000_0000;
            @(negedge clk);
            if (bus.done) begin
                if (d1 == 0) begin
                    d1 = c;
                    n1 = bus.result_norm;
                    s1 = bus.result_shamt;
                end else if (d2 == 0) begin
                    d2 = c;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd2);
        chk("b2b_first_norm", n1, 32'h8000_0000);
        chk("b2b_first_shamt", 32'(s1), 32'd0);
        chk("b2b_second_done", 32'(d2), 32'd6);
        chk("b2b_second_norm", bus.result_norm, 32'hF000_0000);
        chk("b2b_second_shamt", 32'(bus.result_shamt), 32'd8);
        repeat (2) @(negedge clk);
        chk("b2b_idle_after", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of SCAN.
        bus.start     = 1'b1;
        bus.operand_1 = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_norm", bus.result_norm, 32'd0);
        chk("rst_mid_shamt", 32'(bus.result_shamt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_after_idle", 32'(bus.busy), 32'd0);

        run_op("post_rst_clz", FUNCT2_CLZ, 32'h0000_0100, 32'h8000_0000, 6'd23, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
